// File: rtl/quantize_pipe.sv
// Multi-lane requantizer: round, arithmetic right shift and clamp of signed
// accumulator lanes in a 2-stage valid/ready pipeline with a per-layer config bank.
module quantize_pipe #(
  parameter int IN_WIDTH    = 23,
  parameter int OUT_WIDTH   = 8,
  parameter int LANES       = 4,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         srstn,
  input  logic                         cfg_load,
  input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
  input  logic                         cfg_round,
  input  logic                         cfg_relu,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_WIDTH-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic                         busy,
  output logic [15:0]                  sat_count
);

  localparam int ACC_W = IN_WIDTH + 1;
  localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] NEG_MIN = ACC_W'(-(2 ** (OUT_WIDTH - 1)));

  // Shifts of IN_WIDTH or more leave only the sign; with rounding the half-LSB
  // addend always lifts the sum into [0, 2^shift), so the result is 0.
  function automatic logic signed [ACC_W-1:0] shift_round(
    input logic signed [IN_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]     sh,
    input logic                       rnd
  );
    logic signed [ACC_W-1:0] ext_v;
    logic signed [ACC_W-1:0] half_v;
    logic signed [ACC_W-1:0] sum_v;
    ext_v  = {x[IN_WIDTH-1], x};
    half_v = {ACC_W{1'b0}};
    sum_v  = {ACC_W{1'b0}};
    if (int'(sh) >= IN_WIDTH) begin
      shift_round = rnd ? {ACC_W{1'b0}} : {ACC_W{x[IN_WIDTH-1]}};
    end else begin
      if (rnd && (sh != {SHIFT_WIDTH{1'b0}})) begin
        half_v = {{(ACC_W-1){1'b0}}, 1'b1} << (sh - {{(SHIFT_WIDTH-1){1'b0}}, 1'b1});
      end else begin
        half_v = {ACC_W{1'b0}};
      end
      sum_v       = ext_v + half_v;
      shift_round = sum_v >>> sh;
    end
  endfunction

  // Returns {saturated, value}.
  function automatic logic [OUT_WIDTH:0] clamp_lane(
    input logic signed [ACC_W-1:0] v,
    input logic                    neg,
    input logic                    relu
  );
    if (relu && neg) begin
      clamp_lane = {1'b0, {OUT_WIDTH{1'b0}}};
    end else if (v > POS_MAX) begin
      clamp_lane = {1'b1, POS_MAX[OUT_WIDTH-1:0]};
    end else if (!relu && (v < NEG_MIN)) begin
      clamp_lane = {1'b1, NEG_MIN[OUT_WIDTH-1:0]};
    end else begin
      clamp_lane = {1'b0, v[OUT_WIDTH-1:0]};
    end
  endfunction

  logic [SHIFT_WIDTH-1:0]  cfg_shift_r;
  logic                    cfg_round_r;
  logic                    cfg_relu_r;
  logic                    s1_valid_r;
  logic signed [ACC_W-1:0] s1_data_r [LANES];
  logic [LANES-1:0]        s1_neg_r;
  logic                    out_valid_r;
  logic [LANES*OUT_WIDTH-1:0] out_data_r;
  logic [15:0]             sat_count_r;

  logic                    s2_adv_s;
  logic                    s1_adv_s;
  logic                    cfg_accept_s;
  logic signed [ACC_W-1:0] s1_next_s [LANES];
  logic [LANES*OUT_WIDTH-1:0] clamp_data_s;
  logic [16:0]             sat_sum_s;
  logic [15:0]             sat_next_s;

  assign s2_adv_s     = !out_valid_r || out_ready;
  assign s1_adv_s     = !s1_valid_r || s2_adv_s;
  assign cfg_accept_s = cfg_load && !busy && !in_valid;

  assign in_ready  = s1_adv_s;
  assign busy      = s1_valid_r || out_valid_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign sat_count = sat_count_r;

  // Per-lane datapath of both stages plus the saturation counter update.
  always_comb begin
    logic [OUT_WIDTH:0] lane_v;
    clamp_data_s = {(LANES*OUT_WIDTH){1'b0}};
    sat_sum_s    = {1'b0, sat_count_r};
    for (int i = 0; i < LANES; i++) begin
      s1_next_s[i] = shift_round(in_data[i*IN_WIDTH +: IN_WIDTH], cfg_shift_r, cfg_round_r);
      lane_v = clamp_lane(s1_data_r[i], s1_neg_r[i], cfg_relu_r);
      clamp_data_s[i*OUT_WIDTH +: OUT_WIDTH] = lane_v[OUT_WIDTH-1:0];
      sat_sum_s = sat_sum_s + {16'd0, lane_v[OUT_WIDTH]};
    end
    if (cfg_accept_s) begin
      sat_next_s = 16'd0;
    end else if (s2_adv_s && s1_valid_r) begin
      sat_next_s = sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
    end else begin
      sat_next_s = sat_count_r;
    end
  end

  // Config bank and saturation counter.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      cfg_shift_r <= SHIFT_WIDTH'(6);
      cfg_round_r <= 1'b1;
      cfg_relu_r  <= 1'b1;
      sat_count_r <= 16'd0;
    end else begin
      if (cfg_accept_s) begin
        cfg_shift_r <= cfg_shift;
        cfg_round_r <= cfg_round;
        cfg_relu_r  <= cfg_relu;
      end
      sat_count_r <= sat_next_s;
    end
  end

  // Pipeline stage registers; data only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      s1_valid_r  <= 1'b0;
      s1_neg_r    <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {(LANES*OUT_WIDTH){1'b0}};
      for (int i = 0; i < LANES; i++) begin
        s1_data_r[i] <= {ACC_W{1'b0}};
      end
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            s1_data_r[i] <= s1_next_s[i];
            s1_neg_r[i]  <= s1_next_s[i][ACC_W-1];
          end
        end
      end
      if (s2_adv_s) begin
        out_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          out_data_r <= clamp_data_s;
        end
      end
    end
  end

endmodule
